// File: rtl/mux_8_to_1.sv
// Registered 8-to-1 single-bit multiplexer with a capture-valid flag.
// Optional registered one-hot select output enabled by `define MUX_8_TO_1_ONEHOT_EN.
module mux_8_to_1 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] i,
    input  logic [2:0] s,
`ifdef MUX_8_TO_1_ONEHOT_EN
    output logic [7:0] sel_oh,
`endif
    output logic       y,
    output logic       y_valid
);

    logic next_y_s;
    logic y_r;
    logic y_valid_r;

    // Bit select by direct index so only i[s] reaches the output path.
    always_comb begin
        next_y_s = i[s];
    end

    // Output register: reset dominates, capture on en, otherwise hold y and drop valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_r       <= RESET_VAL;
            y_valid_r <= 1'b0;
        end else if (en) begin
            y_r       <= next_y_s;
            y_valid_r <= 1'b1;
        end else begin
            y_r       <= y_r;
            y_valid_r <= 1'b0;
        end
    end

    assign y       = y_r;
    assign y_valid = y_valid_r;

`ifdef MUX_8_TO_1_ONEHOT_EN
    logic [7:0] next_oh_s;
    logic [7:0] sel_oh_r;

    // One-hot decode of the select, captured alongside y.
    always_comb begin
        next_oh_s = 8'h01 << s;
    end

    // One-hot register shares reset and enable behaviour with y.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_oh_r <= 8'h00;
        end else if (en) begin
            sel_oh_r <= next_oh_s;
        end else begin
            sel_oh_r <= sel_oh_r;
        end
    end

    assign sel_oh = sel_oh_r;
`endif

endmodule

// File: tb/tb_mux_8_to_1.sv
// Directed self-checking bench for mux_8_to_1; two instances cover RESET_VAL=0 and RESET_VAL=1.
module tb_mux_8_to_1;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] i;
    logic [2:0] s;
    logic       y0, y0_valid;
    logic       y1, y1_valid;
`ifdef MUX_8_TO_1_ONEHOT_EN
    logic [7:0] sel_oh0;
    logic [7:0] sel_oh1;
`endif

    int tests;
    int fails;

    mux_8_to_1 #(.RESET_VAL(1'b0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .i(i), .s(s),
`ifdef MUX_8_TO_1_ONEHOT_EN
        .sel_oh(sel_oh0),
`endif
        .y(y0), .y_valid(y0_valid)
    );

    mux_8_to_1 #(.RESET_VAL(1'b1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .i(i), .s(s),
`ifdef MUX_8_TO_1_ONEHOT_EN
        .sel_oh(sel_oh1),
`endif
        .y(y1), .y_valid(y1_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; i = 8'hFF; s = 3'd4;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) begin rst = 1'b0; en = 1'b0; end
            tick();
            tests++;
            if (y0 !== 1'b0) begin fails++; $display("FAIL reset_y edge%0d got %b want 0", k, y0); end
            tests++;
            if (y0_valid !== 1'b0) begin fails++; $display("FAIL reset_valid edge%0d got %b want 0", k, y0_valid); end
            tests++;
            if (y1 !== 1'b1) begin fails++; $display("FAIL reset_y_rv1 edge%0d got %b want 1", k, y1); end
`ifdef MUX_8_TO_1_ONEHOT_EN
            tests++;
            if (sel_oh0 !== 8'h00) begin fails++; $display("FAIL reset_oh edge%0d got %h want 00", k, sel_oh0); end
`endif
        end
    endtask

    task automatic test_directed();
        logic [7:0] vi [5] = '{8'h11, 8'hFF, 8'h51, 8'h1D, 8'h71};
        logic [2:0] vs [5] = '{3'd1, 3'd7, 3'd5, 3'd0, 3'd3};
        logic       vy [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            i = vi[k]; s = vs[k];
            tick();
            tests++;
            if (y0 !== vy[k]) begin fails++; $display("FAIL directed_y #%0d got %b want %b", k, y0, vy[k]); end
            tests++;
            if (y0_valid !== 1'b1) begin fails++; $display("FAIL directed_valid #%0d got %b want 1", k, y0_valid); end
        end
    endtask

    task automatic test_walk();
        logic [7:0] oh;
        en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            oh = 8'h01 << k;
            s = 3'(k);
            i = oh;
            tick();
            tests++;
            if (y0 !== 1'b1) begin fails++; $display("FAIL walk_hot s=%0d got %b want 1", k, y0); end
`ifdef MUX_8_TO_1_ONEHOT_EN
            tests++;
            if (sel_oh0 !== oh) begin fails++; $display("FAIL walk_oh s=%0d got %h want %h", k, sel_oh0, oh); end
`endif
            i = ~oh;
            tick();
            tests++;
            if (y0 !== 1'b0) begin fails++; $display("FAIL walk_cold s=%0d got %b want 0", k, y0); end
            tests++;
            if (y0_valid !== 1'b1) begin fails++; $display("FAIL walk_valid s=%0d got %b want 1", k, y0_valid); end
        end
    endtask

    task automatic test_hold();
        en = 1'b1; i = 8'h80; s = 3'd7;
        tick();
        tests++;
        if (y0 !== 1'b1) begin fails++; $display("FAIL hold_capture got %b want 1", y0); end
        en = 1'b0; i = 8'h00; s = 3'd2;
        for (int k = 0; k < 3; k++) begin
            tick();
            tests++;
            if (y0 !== 1'b1) begin fails++; $display("FAIL hold_y cyc%0d got %b want 1", k, y0); end
            tests++;
            if (y0_valid !== 1'b0) begin fails++; $display("FAIL hold_valid cyc%0d got %b want 0", k, y0_valid); end
`ifdef MUX_8_TO_1_ONEHOT_EN
            tests++;
            if (sel_oh0 !== 8'h80) begin fails++; $display("FAIL hold_oh cyc%0d got %h want 80", k, sel_oh0); end
`endif
        end
    endtask

    task automatic test_reset_priority();
        en = 1'b1; i = 8'h00; s = 3'd2;
        tick();
        rst = 1'b1; en = 1'b1; i = 8'hFF; s = 3'd2;
        tick();
        rst = 1'b0;
        tests++;
        if (y0 !== 1'b0) begin fails++; $display("FAIL prio_y_rv0 got %b want 0", y0); end
        tests++;
        if (y1 !== 1'b1) begin fails++; $display("FAIL prio_y_rv1 got %b want 1", y1); end
        tests++;
        if (y0_valid !== 1'b0 || y1_valid !== 1'b0) begin
            fails++; $display("FAIL prio_valid got %b/%b want 0/0", y0_valid, y1_valid);
        end
`ifdef MUX_8_TO_1_ONEHOT_EN
        tests++;
        if (sel_oh0 !== 8'h00) begin fails++; $display("FAIL prio_oh got %h want 00", sel_oh0); end
`endif
        en = 1'b1; i = 8'h04; s = 3'd2;
        tick();
        tests++;
        if (y1 !== 1'b1 || y1_valid !== 1'b1) begin
            fails++; $display("FAIL prio_resume got y=%b v=%b want y=1 v=1", y1, y1_valid);
        end
    endtask

    task automatic test_isolation();
        en = 1'b1; i = 8'bzzzz1xxx; s = 3'd3;
        tick();
        tests++;
        if (y0 !== 1'b1) begin fails++; $display("FAIL iso_xz got %b want 1", y0); end
        i = 8'h01; s = 3'd0;
        tick();
        tests++;
        if (y0 !== 1'b1) begin fails++; $display("FAIL iso_capture got %b want 1", y0); end
        i = 8'h00;
        #2;
        tests++;
        if (y0 !== 1'b1) begin fails++; $display("FAIL iso_mid1 got %b want 1", y0); end
        i = 8'hFF; s = 3'd6;
        #2;
        tests++;
        if (y0 !== 1'b1) begin fails++; $display("FAIL iso_mid2 got %b want 1", y0); end
        i = 8'h00; s = 3'd5;
        tick();
        tests++;
        if (y0 !== 1'b0) begin fails++; $display("FAIL iso_edge got %b want 0", y0); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1; en = 1'b0; i = 8'h00; s = 3'd0;
        test_reset();
        test_directed();
        test_walk();
        test_hold();
        test_reset_priority();
        test_isolation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
